msk_state_loader: RTL and testbench
===================================

Name: msk_state_loader

Overview:
- Masked serial-to-parallel loader feeding the masked round-state register (enable/reset masked register) of the PRESENT HPC core.
- Accepts a d-share plaintext sharing over a narrow valid/ready bus, W sensitive bits per beat.
- Assembles the full count-bit sharing and presents it with out_valid. The core asserts out_ready to pulse the state-register enable.
- Share wires pass only through flops and muxes controlled by non-sensitive control signals. Shares are never combined, so the block is affine for composition and formal checks.

Parameters:
- d, 2, number of shares per sensitive bit (masking order + 1).
- count, 64, sensitive bits in the assembled state.
- W, 4, sensitive bits per input beat. count must be divisible by W.
- N (localparam), count/W, number of beats per block.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort of the current block (control, non-sensitive).
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_data  input  W*d  beat sharing. Bits [i*d +: d] are the d shares of beat bit i.
- out_valid  output  1  assembled sharing available.
- out_ready  input  1  consumer takes the block when out_valid && out_ready.
- out_data  output  count*d  assembled sharing, same bit-major share layout.
- busy  output  1  high when 0 < beat counter < N, i.e. a partial block is held.

Behaviour:
- Interface: single clock domain, clk. rst is asynchronous and active-high.
- State: FILL or FULL.
  - Beat counter cnt has width clog2(N+1).
  - Buffer buf is count*d bits. out_data = buf, driven directly from flops.
- Reset (rst=1, asynchronous):
  - state=FILL, cnt=0, buf=0.
  - out_valid=0, in_ready=1 after release, busy=0.
- Shift rule, on every accepted beat:
  - buf <= {in_data, buf[count*d-1 : W*d]}.
  - After N beats, beat 0 occupies out_data[W*d-1:0] and beat N-1 occupies the top.
- FILL:
  - in_ready=1, out_valid=0.
  - On in handshake: shift, cnt<=cnt+1.
  - If cnt==N-1, go to FULL with cnt<=N.
- FULL:
  - out_valid=1, in_ready=out_ready.
  - out handshake without in handshake: state<=FILL, cnt<=0. buf is not cleared; stale contents are don't-care.
  - out handshake with simultaneous in handshake:
    - Shift the beat into buf. The outgoing block is the pre-edge buf.
    - cnt<=1 and state<=FILL.
    - If N==1, stay FULL with cnt=N.
  - No out handshake: hold everything. in_data is ignored because in_ready=0.
- clr (synchronous, highest priority after rst):
  - in_ready=0 while clr=1. No beat and no out handshake takes effect.
  - Next state=FILL, cnt=0, out_valid=0. buf is held, not zeroed.
- Latency:
  - out_valid rises the cycle after the N-th accepted beat.
  - Minimum block period is N cycles (back-to-back, drain overlapped with the first beat).
- Stability: out_data and out_valid are stable while out_valid=1 and out_ready=0.
- busy = (state==FILL && cnt!=0).
- Security rules:
  - No XOR/AND of two shares of the same bit anywhere.
  - Control signals (state, cnt, handshakes) never depend on share values.
  - in_valid, out_ready and clr are control-typed.
- Elaboration: fail elaboration if count % W != 0 or W > count.

Test Plan:
- Reset and idle: assert rst mid-fill after 5 beats -> out_valid=0, busy=0, out_data=0 immediately (asynchronously). After release, a full 16-beat load completes normally.
- Basic load (d=2, count=64, W=4, N=16):
  - Stimulus: beats k=0..15 with in_data = {k[3:0],~k[3:0]}, in_valid held high.
  - Required: out_valid rises one cycle after beat 15. out_data[15:0]=8'h0F,8'h1E (beat 1 above beat 0), and the top byte is 8'hF0.
- Backpressure: hold out_ready=0 for 10 cycles after FULL with in_valid=1 -> in_ready=0 throughout, out_data unchanged. Then out_ready=1 -> block accepted and next beat accepted the same cycle, cnt=1.
- Back-to-back: two blocks with in_valid and out_ready tied high -> out_valid pulses every 16 cycles, with no lost or duplicated beats (compare both blocks against a model).
- clr: clr for one cycle after 7 beats, with in_valid=1 that cycle -> the beat is not accepted and busy=0 next cycle. A fresh 16-beat load yields exactly the new data.
- Share independence: randomize share 1 while keeping each unmasked bit fixed -> the XOR-recombined out_data is constant, and the control outputs are identical across runs.

Source files
------------

// File: rtl/msk_state_loader.sv
// Masked serial-to-parallel loader for the PRESENT HPC round-state register.
// Collects N beats of W shared bits into a count*d-bit sharing. Shares only
// pass through flops and muxes, and every mux select is a control signal.
module msk_state_loader #(
  parameter int d     = 2,
  parameter int count = 64,
  parameter int W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W*d-1:0]       in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [count*d-1:0]   out_data,
  output logic                 busy
);

  localparam int N  = count / W;
  localparam int CW = $clog2(N + 1);
  localparam int BW = count * d;
  localparam int SW = W * d;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // A block must be a whole number of beats and hold at least one beat.
  if ((count % W) != 0 || W > count) begin : g_bad_params
    $error("msk_state_loader: count must be a nonzero multiple of W");
  end

  typedef enum logic {FILL, FULL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   buf_q;
  logic [BW-1:0]   buf_shifted;
  logic            load;
  logic            in_hs;
  logic            out_hs;

  // New beats enter at the top so beat 0 ends up in the lowest slice.
  if (N == 1) begin : g_single
    assign buf_shifted = in_data;
  end else begin : g_multi
    assign buf_shifted = {in_data, buf_q[BW-1:SW]};
  end

  // Handshakes, next state and counter; clr blocks both handshakes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    out_valid = (state_q == FULL);
    in_ready  = !clr && ((state_q == FILL) || out_ready);
    in_hs     = in_valid && in_ready;
    out_hs    = out_valid && out_ready && !clr;

    if (clr) begin
      state_d = FILL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_hs) begin
            load = 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_d = FULL;
              cnt_d   = CNT_FULL;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        FULL: begin
          if (out_hs) begin
            if (in_hs) begin
              load = 1'b1;
              if (N == 1) begin
                state_d = FULL;
                cnt_d   = CNT_FULL;
              end else begin
                state_d = FILL;
                cnt_d   = CNT_ONE;
              end
            end else begin
              state_d = FILL;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Share buffer; only written on an accepted beat, never cleared by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (load) begin
      buf_q <= buf_shifted;
    end
  end

  assign out_data = buf_q;
  assign busy     = (state_q == FILL) && (cnt_q != '0);

endmodule

// File: tb/tb_msk_state_loader.sv
// Self-checking bench for msk_state_loader (d=2, count=64, W=4, N=16).
// A reference model at the falling edge predicts handshakes and pushes each
// completed block to a scoreboard queue; out_data is compared while valid.
module tb_msk_state_loader;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int passes = 0;

  msk_state_loader #(.d(2), .count(64), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] data;
    logic       ordy;
    logic       exp_ir;
    logic       exp_ov;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[17];

  logic [127:0] sb[$];
  logic [7:0]   m_beats[$];
  int           m_cnt;
  logic         m_full;
  logic         m_ir;
  logic [127:0] m_blk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: predicts control outputs and tracks the expected block.
  always @(negedge clk) begin
    if (rst) begin
      m_cnt  = 0;
      m_full = 1'b0;
      m_beats.delete();
      sb.delete();
    end else begin
      m_ir = !clr && (!m_full || out_ready);
      check("mon_in_ready", 128'(in_ready), 128'(m_ir));
      check("mon_out_valid", 128'(out_valid), 128'(m_full));
      check("mon_busy", 128'(busy), 128'(!m_full && m_cnt != 0));
      if (m_full) begin
        if (sb.size() == 0) check("mon_sb_nonempty", 128'(0), 128'(1));
        else check("mon_out_data", out_data, sb[0]);
      end
      if (clr) begin
        m_cnt  = 0;
        m_full = 1'b0;
        m_beats.delete();
      end else begin
        if (m_full && out_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          m_full = 1'b0;
          m_cnt  = 0;
        end
        if (in_valid && m_ir) begin
          m_beats.push_back(in_data);
          m_cnt++;
          if (m_cnt == 16) begin
            m_blk = '0;
            for (int k = 0; k < 16; k++) m_blk[k*8 +: 8] = m_beats[k];
            sb.push_back(m_blk);
            m_beats.delete();
            m_full = 1'b1;
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] data, input logic ordy, input logic c);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = data;
    out_ready = ordy;
    clr       = c;
  endtask

  task automatic applyStimulus(input vec_t t);
    drive(t.v, t.data, t.ordy, 1'b0);
  endtask

  task automatic checkOutput(input vec_t t, input int idx);
    #1;
    check($sformatf("tbl%0d_in_ready", idx), 128'(in_ready), 128'(t.exp_ir));
    check($sformatf("tbl%0d_out_valid", idx), 128'(out_valid), 128'(t.exp_ov));
    check($sformatf("tbl%0d_busy", idx), 128'(busy), 128'(t.exp_busy));
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_and_drain(input string tag);
    for (int k = 0; k < 16; k++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check({tag, "_out_valid_up"}, 128'(out_valid), 128'(1));
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check({tag, "_out_valid_down"}, 128'(out_valid), 128'(0));
  endtask

  function automatic logic [7:0] make_beat(input logic [3:0] u, input logic [3:0] r);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b[2*i]   = r[i];
      b[2*i+1] = u[i] ^ r[i];
    end
    return b;
  endfunction

  // Bail out if the sequence never finishes.
  initial begin
    #50000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int           pulses;
    int           first_idx;
    int           second_idx;
    logic [63:0]  u_val;
    logic [63:0]  recomb;
    logic [3:0]   kn;

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Basic-load vectors: beat k = {k, ~k}, then one cycle held FULL.
    for (int k = 0; k < 16; k++) begin
      kn = 4'(k);
      tbl[k] = '{v: 1'b1, data: {kn, ~kn}, ordy: 1'b0,
                 exp_ir: 1'b1, exp_ov: 1'b0, exp_busy: (k != 0)};
    end
    tbl[16] = '{v: 1'b1, data: 8'hAA, ordy: 1'b0, exp_ir: 1'b0, exp_ov: 1'b1, exp_busy: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_data", out_data, 128'(0));

    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], i);
    end
    check("basic_low16", 128'(out_data[15:0]), 128'(16'h1E0F));
    check("basic_top8", 128'(out_data[127:120]), 128'(8'hF0));

    // Backpressure: ten cycles with out_ready low, then a combined handshake.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'($urandom), 1'b0, 1'b0);
      #1;
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_low16", 128'(out_data[15:0]), 128'(16'h1E0F));
    end
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    #1;
    check("bp_release_in_ready", 128'(in_ready), 128'(1));
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("bp_cnt1_busy", 128'(busy), 128'(1));
    check("bp_cnt1_out_valid", 128'(out_valid), 128'(0));

    // Asynchronous reset in the middle of a fill (5 beats held).
    for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_async_out_valid", 128'(out_valid), 128'(0));
    check("rst_async_busy", 128'(busy), 128'(0));
    check("rst_async_out_data", out_data, 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", 128'(in_ready), 128'(1));
    load_and_drain("after_rst");

    // clr after 7 beats, with a beat offered during the clr cycle.
    for (int i = 0; i < 7; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 8'hC3, 1'b0, 1'b1);
    #1;
    check("clr_in_ready", 128'(in_ready), 128'(0));
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("clr_busy", 128'(busy), 128'(0));
    load_and_drain("after_clr");

    // Back-to-back blocks with both sides always ready.
    reset_pulse();
    pulses = 0; first_idx = -1; second_idx = -1;
    for (int i = 0; i < 48; i++) begin
      drive(1'b1, 8'($urandom), 1'b1, 1'b0);
      #1;
      if (out_valid) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
        else if (second_idx < 0) second_idx = i;
      end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("b2b_pulses", 128'(pulses), 128'(2));
    check("b2b_first", 128'(first_idx), 128'(16));
    check("b2b_period", 128'(second_idx - first_idx), 128'(16));

    // Share independence: same unmasked value, fresh random share per run.
    u_val = 64'h0123_4567_89AB_CDEF;
    for (int r = 0; r < 2; r++) begin
      reset_pulse();
      for (int k = 0; k < 16; k++)
        drive(1'b1, make_beat(u_val[k*4 +: 4], 4'($urandom)), 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      check($sformatf("share_run%0d_out_valid", r), 128'(out_valid), 128'(1));
      for (int i = 0; i < 64; i++) recomb[i] = out_data[2*i] ^ out_data[2*i+1];
      check($sformatf("share_run%0d_recombined", r), 128'(recomb), 128'(u_val));
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
    end

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
